// File: rtl/spi_master_param.sv
// SPI master: parameterised word width, slave-select count and sclk divider, runtime cpol/cpha.
// Define SPI_MASTER_LSB_FIRST_EN to shift both directions LSB first (default MSB first).
`timescale 1ns/1ps
module spi_master_param #(
  parameter int DATA_W  = 8,
  parameter int SEL_W   = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SEL_W-1:0]      slave_sel,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic [DATA_W-1:0]     data_in,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [(2**SEL_W)-1:0] ss_n,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_W-1:0]     data_out
);
  localparam int N_SLAVES = 2**SEL_W;
  localparam int CNT_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EDGE_W   = $clog2(2*DATA_W);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(CLK_DIV-1);
  localparam logic [EDGE_W-1:0] EDGE_MAX = EDGE_W'(2*DATA_W-1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [EDGE_W-1:0]   edge_q, edge_d;
  logic                cpol_q, cpol_d, cpha_q, cpha_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [DATA_W-1:0]   tx_q, tx_d, rx_q, rx_d, dout_q, dout_d;
  logic                sclk_q, sclk_d, mosi_q, mosi_d, done_q, done_d;
  logic                last_tick, sample_edge;

`ifdef SPI_MASTER_LSB_FIRST_EN
  function automatic logic tx_bit(input logic [DATA_W-1:0] w);
    return w[0];
  endfunction
  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
    return w >> 1;
  endfunction
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
    return {b, w[DATA_W-1:1]};
  endfunction
`else
  function automatic logic tx_bit(input logic [DATA_W-1:0] w);
    return w[DATA_W-1];
  endfunction
  function automatic logic [DATA_W-1:0] tx_shift(input logic [DATA_W-1:0] w);
    return w << 1;
  endfunction
  function automatic logic [DATA_W-1:0] rx_shift(input logic [DATA_W-1:0] w, input logic b);
    return {w[DATA_W-2:0], b};
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      edge_q  <= '0;
      cpol_q  <= 1'b0;
      cpha_q  <= 1'b0;
      sel_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      dout_q  <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      edge_q  <= edge_d;
      cpol_q  <= cpol_d;
      cpha_q  <= cpha_d;
      sel_q   <= sel_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      done_q  <= done_d;
    end
  end

  // Handshake: start is a request with implicit ready = !busy; a start seen while busy is dropped.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    edge_d      = edge_q;
    cpol_d      = cpol_q;
    cpha_d      = cpha_q;
    sel_d       = sel_q;
    tx_d        = tx_q;
    rx_d        = rx_q;
    dout_d      = dout_q;
    sclk_d      = sclk_q;
    mosi_d      = mosi_q;
    done_d      = 1'b0;
    sample_edge = 1'b0;
    last_tick   = (cnt_q == CNT_MAX);
    if (state_q != IDLE) cnt_d = last_tick ? '0 : cnt_q + CNT_W'(1);
    case (state_q)
      IDLE: if (start) begin
        state_d = SETUP;
        cnt_d   = '0;
        edge_d  = '0;
        cpol_d  = cpol;
        cpha_d  = cpha;
        sel_d   = slave_sel;
        sclk_d  = cpol;
        rx_d    = '0;
        if (cpha) begin
          mosi_d = 1'b0;
          tx_d   = data_in;
        end else begin
          mosi_d = tx_bit(data_in);
          tx_d   = tx_shift(data_in);
        end
      end
      SETUP: if (last_tick) state_d = XFER;
      XFER: if (last_tick) begin
        sclk_d = ~sclk_q;
        // Even edges lead, odd edges trail; cpha picks which kind samples miso.
        sample_edge = (edge_q[0] == cpha_q);
        if (sample_edge) begin
          rx_d = rx_shift(rx_q, miso);
        end else begin
          mosi_d = tx_bit(tx_q);
          tx_d   = tx_shift(tx_q);
        end
        if (edge_q == EDGE_MAX) begin
          state_d = HOLD;
          edge_d  = '0;
        end else begin
          edge_d = edge_q + EDGE_W'(1);
        end
      end
      HOLD: if (last_tick) begin
        state_d = IDLE;
        done_d  = 1'b1;
        dout_d  = rx_q;
        mosi_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ss_n = {N_SLAVES{1'b1}};
    if (state_q != IDLE) ss_n[sel_q] = 1'b0;
  end

  assign busy     = (state_q != IDLE);
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;
  assign done     = done_q;
  assign data_out = dout_q;
endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: directed scenarios then random transfers against a bit-level slave model.
`timescale 1ns/1ps
module tb_spi_master_param;
`ifdef SPI_MASTER_LSB_FIRST_EN
  localparam int DW = 16;
  localparam int CD = 1;
  localparam bit LSB = 1'b1;
`else
  localparam int DW = 8;
  localparam int CD = 4;
  localparam bit LSB = 1'b0;
`endif
  localparam int SW = 2;
  localparam int NS = 4;
  localparam int BUSY_EXP = (2*DW+2)*CD;
  localparam int BUDGET = 4*BUSY_EXP + 20;

  logic clk = 1'b0, rst = 1'b1, start = 1'b0, cpol = 1'b0, cpha = 1'b0, miso = 1'b0;
  logic [SW-1:0] slave_sel = '0;
  logic [DW-1:0] data_in = '0;
  logic sclk, mosi, busy, done;
  logic [NS-1:0] ss_n;
  logic [DW-1:0] data_out;

  spi_master_param #(.DATA_W(DW), .SEL_W(SW), .CLK_DIV(CD)) dut (
    .clk(clk), .rst(rst), .start(start), .slave_sel(slave_sel), .cpol(cpol), .cpha(cpha),
    .data_in(data_in), .miso(miso), .sclk(sclk), .mosi(mosi), .ss_n(ss_n), .busy(busy),
    .done(done), .data_out(data_out)
  );

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  logic [DW-1:0] slave_word = '0;
  logic mode_cpol = 1'b0, mode_cpha = 1'b0;
  logic [SW-1:0] mode_sel = '0;
  logic sel_prev = 1'b0, sclk_prev = 1'b0, sel_now, lead;
  logic [NS-1:0] ss_exp;
  int bit_i = 0, pulses = 0, busy_cnt = 0, done_cnt = 0, ss_err = 0, idle_err = 0;
  logic mon_q[$];
  logic [DW-1:0] exp_q[$];

  function automatic logic nth_bit(input logic [DW-1:0] w, input int i);
    return LSB ? w[i] : w[DW-1-i];
  endfunction

  function automatic logic [DW-1:0] assemble();
    logic [DW-1:0] w = '0;
    for (int i = 0; i < mon_q.size() && i < DW; i++) w[LSB ? i : DW-1-i] = mon_q[i];
    return w;
  endfunction

  // Slave model and bus monitor, evaluated mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      sel_prev = 1'b0;
      sclk_prev = sclk;
      bit_i = 0;
      miso = 1'b0;
    end else begin
      if (busy) busy_cnt++;
      if (done) done_cnt++;
      ss_exp = '1;
      ss_exp[mode_sel] = 1'b0;
      if (busy && ss_n !== ss_exp) ss_err++;
      if (!busy && ss_n !== '1) ss_err++;
      if (!busy && sclk !== mode_cpol) idle_err++;
      sel_now = (ss_n != '1);
      if (sel_now && !sel_prev) begin
        mon_q.delete();
        bit_i = 0;
        pulses = 0;
        if (!mode_cpha) begin
          miso = nth_bit(slave_word, 0);
          bit_i = 1;
        end
      end else if (sel_now && sclk != sclk_prev) begin
        lead = (sclk != mode_cpol);
        if (lead) pulses++;
        if (lead != mode_cpha) mon_q.push_back(mosi);
        else if (bit_i < DW) begin
          miso = nth_bit(slave_word, bit_i);
          bit_i++;
        end
      end
      sel_prev = sel_now;
      sclk_prev = sclk;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_xfer(input logic [DW-1:0] d, input logic [SW-1:0] s, input logic cp,
                            input logic ch, input logic [DW-1:0] sw);
    data_in = d; slave_sel = s; cpol = cp; cpha = ch; start = 1'b1;
    mode_cpol = cp; mode_cpha = ch; mode_sel = s; slave_word = sw;
    busy_cnt = 0; done_cnt = 0; ss_err = 0; idle_err = 0;
    exp_q.push_back(sw);
    tick();
    start = 1'b0;
    data_in = DW'($urandom);
    slave_sel = SW'($urandom);
    cpol = 1'($urandom_range(0, 1));
    cpha = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input string tag);
    int c;
    c = 0;
    while (done !== 1'b1 && c < BUDGET) begin
      tick();
      c++;
    end
    check({tag, "_done_seen"}, 32'(done), 32'd1);
  endtask

  task automatic done_phase(input string tag, input logic [DW-1:0] d);
    logic [DW-1:0] exp_w;
    wait_done(tag);
    exp_w = (exp_q.size() != 0) ? exp_q.pop_front() : ~data_out;
    check({tag, "_data_out"}, 32'(data_out), 32'(exp_w));
    check({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    check({tag, "_mosi_idle"}, 32'(mosi), 32'd0);
    check({tag, "_mosi_word"}, 32'(assemble()), 32'(d));
    check({tag, "_first_bit"}, (mon_q.size() > 0) ? 32'(mon_q[0]) : 32'hdead, 32'(nth_bit(d, 0)));
    check({tag, "_pulses"}, 32'(pulses), 32'(DW));
  endtask

  task automatic settle_phase(input string tag, input logic [DW-1:0] sw);
    tick();
    check({tag, "_done_once"}, 32'(done), 32'd0);
    check({tag, "_data_hold"}, 32'(data_out), 32'(sw));
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(BUSY_EXP));
    check({tag, "_done_count"}, 32'(done_cnt), 32'd1);
    check({tag, "_ss_n"}, 32'(ss_err), 32'd0);
    check({tag, "_sclk_idle"}, 32'(idle_err), 32'd0);
  endtask

  task automatic full_xfer(input string tag, input logic [DW-1:0] d, input logic [SW-1:0] s,
                           input logic cp, input logic ch, input logic [DW-1:0] sw);
    begin_xfer(d, s, cp, ch, sw);
    done_phase(tag, d);
    settle_phase(tag, sw);
  endtask

  initial begin
    logic [DW-1:0] d, sw;
    // Reset: outputs must be at their cleared values while rst is held.
    repeat (3) tick();
    check("rst_ss_n", 32'(ss_n), 32'hF);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;
    tick();

    // Mode 0 to slave 2: 0xA5 out, slave echoes 0x3C.
    full_xfer("mode0", DW'(8'hA5), 2'd2, 1'b0, 1'b0, DW'(8'h3C));

    // Mode 3 with miso tied high.
    full_xfer("mode3", DW'(8'h81), 2'd0, 1'b1, 1'b1, '1);
    check("mode3_sclk_idle_high", 32'(sclk), 32'd1);

    // Second start mid-transfer with a different word is ignored.
    begin_xfer(DW'(8'h6B), 2'd3, 1'b0, 1'b1, DW'(8'hD2));
    repeat (9) tick();
    start = 1'b1; data_in = '0;
    tick();
    start = 1'b0;
    done_phase("ignore", DW'(8'h6B));
    settle_phase("ignore", DW'(8'hD2));
    repeat (2) tick();
    check("ignore_no_queue", 32'(busy), 32'd0);

    // Reset mid-transfer aborts immediately.
    begin_xfer(DW'(8'h5A), 2'd1, 1'b1, 1'b0, DW'(8'hC3));
    repeat (29) tick();
    check("abort_busy_before", 32'(busy), 32'd1);
    rst = 1'b1; mode_cpol = 1'b0;
    #1;
    check("abort_ss_n", 32'(ss_n), 32'hF);
    check("abort_sclk", 32'(sclk), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (3) tick();
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_data_out", 32'(data_out), 32'd0);
    rst = 1'b0;
    tick();
    full_xfer("post_rst", DW'(8'hE7), 2'd1, 1'b0, 1'b0, DW'(8'h19));

    // Start held high: second transfer begins right after the first done.
    data_in = DW'(8'h12); slave_sel = 2'd2; cpol = 1'b0; cpha = 1'b0; start = 1'b1;
    mode_cpol = 1'b0; mode_cpha = 1'b0; mode_sel = 2'd2; slave_word = DW'(8'h9E);
    busy_cnt = 0; done_cnt = 0; ss_err = 0; idle_err = 0;
    exp_q.push_back(DW'(8'h9E));
    tick();
    data_in = DW'(8'h34);
    done_phase("b2b_first", DW'(8'h12));
    slave_word = DW'(8'h47);
    exp_q.push_back(DW'(8'h47));
    busy_cnt = 0; done_cnt = 0;
    tick();
    check("b2b_busy_rise", 32'(busy), 32'd1);
    start = 1'b0;
    done_phase("b2b_second", DW'(8'h34));
    settle_phase("b2b_second", DW'(8'h47));

    // Single set bit in bit 0: order of the stream follows the configured bit order.
    full_xfer("bit0", DW'(1), 2'd0, 1'b0, 1'b0, DW'(8'h80));

    for (int k = 0; k < 8; k++) begin
      d  = DW'($urandom);
      sw = DW'($urandom);
      full_xfer($sformatf("rand%0d", k), d, SW'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), sw);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
